// File: rtl/apb_master_if.sv
// Command/response and APB bus bundle for the APB requester stage.
// The master modport is the requester's view; the slave modport is the
// opposite side (command source plus APB completer).
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] P_addr;
  logic              P_selx;
  logic              P_enable;
  logic              P_write;
  logic [DATA_W-1:0] P_wdata;
  logic              P_ready;
  logic              P_slverr;
  logic [DATA_W-1:0] P_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  P_ready, P_slverr, P_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output P_addr, P_selx, P_enable, P_write, P_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output P_ready, P_slverr, P_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  P_addr, P_selx, P_enable, P_write, P_wdata
  );
endinterface

// File: rtl/apb_master.sv
// APB requester: takes single read/write commands on valid/ready, runs the
// SETUP and ACCESS phases, honours wait states, aborts hung transfers after
// TIMEOUT access cycles and returns a one-cycle response pulse.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         P_clk,
  input  logic         P_rst_n,
  apb_master_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Counter value at which a still-unready ACCESS edge aborts the transfer.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q,     state_d;
  logic [7:0]        cnt_q,       cnt_d;
  logic [ADDR_W-1:0] p_addr_q,    p_addr_d;
  logic              p_selx_q,    p_selx_d;
  logic              p_enable_q,  p_enable_d;
  logic              p_write_q,   p_write_d;
  logic [DATA_W-1:0] p_wdata_q,   p_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_addr_d    = p_addr_q;
    p_selx_d    = p_selx_q;
    p_enable_d  = p_enable_q;
    p_write_d   = p_write_q;
    p_wdata_d   = p_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          p_addr_d   = bus.cmd_addr;
          p_write_d  = bus.cmd_write;
          p_wdata_d  = bus.cmd_wdata;
          p_selx_d   = 1'b1;
          p_enable_d = 1'b0;
          state_d    = ST_SETUP;
        end else begin
          p_selx_d   = 1'b0;
          p_enable_d = 1'b0;
        end
      end
      ST_SETUP: begin
        p_enable_d = 1'b1;
        cnt_d      = 8'd0;
        state_d    = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.P_ready) begin
          rsp_err_d   = bus.P_slverr;
          rsp_rdata_d = p_write_q ? {DATA_W{1'b0}} : bus.P_rdata;
          p_selx_d    = 1'b0;
          p_enable_d  = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          // Slave never answered: abort with an error response.
          rsp_err_d   = 1'b1;
          rsp_rdata_d = {DATA_W{1'b0}};
          p_selx_d    = 1'b0;
          p_enable_d  = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        p_selx_d   = 1'b0;
        p_enable_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge P_clk) begin
    if (!P_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      p_addr_q    <= {ADDR_W{1'b0}};
      p_selx_q    <= 1'b0;
      p_enable_q  <= 1'b0;
      p_write_q   <= 1'b0;
      p_wdata_q   <= {DATA_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_addr_q    <= p_addr_d;
      p_selx_q    <= p_selx_d;
      p_enable_q  <= p_enable_d;
      p_write_q   <= p_write_d;
      p_wdata_q   <= p_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE) & P_rst_n;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.P_addr    = p_addr_q;
  assign bus.P_selx    = p_selx_q;
  assign bus.P_enable  = p_enable_q;
  assign bus.P_write   = p_write_q;
  assign bus.P_wdata   = p_wdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: a table of directed transfers, hand
// sequences for reset and mid-transfer reset, and randomized transfers
// checked against a transfer-level reference model.
module tb_apb_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .P_clk   (clk),
    .P_rst_n (rst_n),
    .bus     (bif)
  );

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            nwait;
    logic          slverr;
    logic [DW-1:0] rdata;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_en;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input int nw, input logic se, input logic [DW-1:0] rd,
                              input logic ee, input logic [DW-1:0] er, input int een);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = wd; v.nwait = nw; v.slverr = se; v.rdata = rd;
    v.exp_err = ee; v.exp_rdata = er; v.exp_en = een;
    return v;
  endfunction

  // Transfer-level reference: a slave that stays unready for TO access
  // cycles causes an abort; otherwise the transfer ends on access cycle nwait+1.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit   to_hit;
    r         = v;
    to_hit    = (v.nwait >= TO);
    r.exp_en  = to_hit ? TO : v.nwait + 1;
    r.exp_err = to_hit ? 1'b1 : v.slverr;
    r.exp_rdata = (to_hit || v.write) ? '0 : v.rdata;
    return r;
  endfunction

  // Runs one transfer starting at a negedge in IDLE and checks it cycle by cycle.
  task automatic run_txn(input vec_t v, input string tag);
    int   setup_n = 0;
    int   acc_n = 0;
    bit   done = 0;
    bit   unstable = 0;
    bit   busy_rdy = 0;
    bit   bus_at_rsp = 0;
    logic got_err = 1'b0;
    logic [DW-1:0] got_rd = '0;
    chk({tag, " pre_cmd_ready"}, 64'(bif.cmd_ready), 64'd1);
    bif.cmd_valid = 1'b1;
    bif.cmd_write = v.write;
    bif.cmd_addr  = v.addr;
    bif.cmd_wdata = v.wdata;
    bif.P_ready   = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      // Keep a junk command pending while busy; it must be ignored.
      bif.cmd_addr  = $urandom;
      bif.cmd_wdata = $urandom;
      bif.cmd_write = ~v.write;
      if (bif.rsp_valid) begin
        done    = 1;
        got_err = bif.rsp_err;
        got_rd  = bif.rsp_rdata;
        bus_at_rsp = bif.P_selx | bif.P_enable;
        bif.cmd_valid = 1'b0;
        bif.P_ready   = 1'b0;
      end else begin
        if (bif.P_selx) begin
          if (bif.cmd_ready) busy_rdy = 1;
          if (bif.P_addr !== v.addr || bif.P_write !== v.write || bif.P_wdata !== v.wdata)
            unstable = 1;
        end
        if (bif.P_selx && !bif.P_enable) setup_n++;
        if (bif.P_selx && bif.P_enable) begin
          bif.P_ready  = (acc_n == v.nwait);
          bif.P_slverr = (acc_n == v.nwait) ? v.slverr : 1'($urandom);
          bif.P_rdata  = (acc_n == v.nwait) ? v.rdata : $urandom;
          acc_n++;
        end else begin
          bif.P_ready = 1'b0;
        end
      end
    end
    chk({tag, " rsp_seen"}, 64'(done), 64'd1);
    chk({tag, " setup_cycles"}, 64'(setup_n), 64'd1);
    chk({tag, " enable_cycles"}, 64'(acc_n), 64'(v.exp_en));
    chk({tag, " rsp_err"}, 64'(got_err), 64'(v.exp_err));
    chk({tag, " rsp_rdata"}, 64'(got_rd), 64'(v.exp_rdata));
    chk({tag, " bus_idle_at_rsp"}, 64'(bus_at_rsp), 64'd0);
    chk({tag, " bus_stable"}, 64'(unstable), 64'd0);
    chk({tag, " busy_cmd_ready"}, 64'(busy_rdy), 64'd0);
    @(negedge clk);
    chk({tag, " rsp_single_pulse"}, 64'(bif.rsp_valid), 64'd0);
    chk({tag, " post_cmd_ready"}, 64'(bif.cmd_ready), 64'd1);
    chk({tag, " post_selx"}, 64'(bif.P_selx), 64'd0);
    chk({tag, " post_addr_held"}, 64'(bif.P_addr), 64'(v.addr));
    chk({tag, " post_rdata_held"}, 64'(bif.rsp_rdata), 64'(v.exp_rdata));
    chk({tag, " post_err_held"}, 64'(bif.rsp_err), 64'(v.exp_err));
  endtask

  vec_t tbl[7];
  vec_t rv;
  bit   rsp_seen_after_rst;

  initial begin
    tbl[0] = mk(1'b1, 32'h4,  32'h7,  0,   1'b0, 32'hDEAD, 1'b0, 32'h0,  1);
    tbl[1] = mk(1'b0, 32'h4,  32'h0,  2,   1'b0, 32'h5,    1'b0, 32'h5,  3);
    tbl[2] = mk(1'b0, 32'h8,  32'h0,  0,   1'b1, 32'h11,   1'b1, 32'h11, 1);
    tbl[3] = mk(1'b1, 32'hC,  32'h55, 0,   1'b0, 32'h77,   1'b0, 32'h0,  1);
    tbl[4] = mk(1'b0, 32'h10, 32'h0,  100, 1'b0, 32'h33,   1'b1, 32'h0,  16);
    tbl[5] = mk(1'b0, 32'h14, 32'h0,  15,  1'b0, 32'h99,   1'b0, 32'h99, 16);
    tbl[6] = mk(1'b1, 32'h18, 32'hA5, 16,  1'b0, 32'h0,    1'b1, 32'h0,  16);

    bif.cmd_valid = 1'b0; bif.cmd_write = 1'b0; bif.cmd_addr = '0; bif.cmd_wdata = '0;
    bif.P_ready = 1'b0; bif.P_slverr = 1'b0; bif.P_rdata = '0;

    // Reset for two cycles: all outputs low, cmd_ready low.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst cmd_ready", 64'(bif.cmd_ready), 64'd0);
    chk("rst outputs", {bif.rsp_valid, bif.rsp_err, bif.P_selx, bif.P_enable, bif.P_write},
        64'd0);
    chk("rst buses", 64'(bif.P_addr | bif.P_wdata | bif.rsp_rdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel cmd_ready", 64'(bif.cmd_ready), 64'd1);
    chk("rel selx", 64'(bif.P_selx), 64'd0);

    for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Reset during ACCESS of a read: bus idles at that edge, no response.
    bif.cmd_valid = 1'b1; bif.cmd_write = 1'b0; bif.cmd_addr = 32'h20; bif.P_ready = 1'b0;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    @(negedge clk);
    chk("mrst in_access", 64'(bif.P_enable), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst bus_idle", {bif.P_selx, bif.P_enable}, 64'd0);
    chk("mrst no_rsp", 64'(bif.rsp_valid), 64'd0);
    chk("mrst cmd_ready", 64'(bif.cmd_ready), 64'd0);
    rst_n = 1'b1;
    rsp_seen_after_rst = 0;
    repeat (3) begin
      @(negedge clk);
      if (bif.rsp_valid) rsp_seen_after_rst = 1;
    end
    chk("mrst no_late_rsp", 64'(rsp_seen_after_rst), 64'd0);
    run_txn(mk(1'b1, 32'h24, 32'hBEEF, 1, 1'b0, 32'h0, 1'b0, 32'h0, 2), "post_rst");

    // Randomized transfers against the reference model.
    for (int i = 0; i < 25; i++) begin
      rv.write  = 1'($urandom);
      rv.addr   = $urandom;
      rv.wdata  = $urandom;
      rv.nwait  = $urandom_range(0, 20);
      rv.slverr = ($urandom_range(0, 3) == 0);
      rv.rdata  = $urandom;
      rv = model(rv);
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
